// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the arena game.
//               - Six one-hot action codes plus ACT_NOP.
//               - The action bus width.
//               - The encoder state enumeration.
//               - A priority encoder from mapped presses to an action code.
//               The fighter modules import the same codes from here.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int ACT_W = 6;

    localparam logic [ACT_W-1:0] ACT_MOVE_RIGHT = 6'b100000;
    localparam logic [ACT_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
    localparam logic [ACT_W-1:0] ACT_WAIT       = 6'b001000;
    localparam logic [ACT_W-1:0] ACT_JUMP       = 6'b000100;
    localparam logic [ACT_W-1:0] ACT_KICK       = 6'b000010;
    localparam logic [ACT_W-1:0] ACT_PUNCH      = 6'b000001;
    localparam logic [ACT_W-1:0] ACT_NOP        = 6'b000000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Input bit order is {move_right, move_left, jump, kick, punch}, taken
    // after mirroring. The lowest set bit wins:
    // PUNCH > KICK > JUMP > MOVE_LEFT > MOVE_RIGHT.
    function automatic logic [ACT_W-1:0] encode_press(input logic [4:0] p);
        logic [ACT_W-1:0] code;
        code = ACT_NOP;
        if (p[0])      code = ACT_PUNCH;
        else if (p[1]) code = ACT_KICK;
        else if (p[2]) code = ACT_JUMP;
        else if (p[3]) code = ACT_MOVE_LEFT;
        else if (p[4]) code = ACT_MOVE_RIGHT;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_action_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : player_action_encoder_if
// Description : Button inputs and action outputs of the player encoder.
//   enable        : game active
//   round_tick    : one-cycle round boundary pulse
//   btn_*         : synchronised button levels
//   action        : one-hot action code
//   action_strobe : one-cycle pulse on each action update
//   busy          : high while in cooldown
//   Modport master : the encoder (drives action, strobe and busy).
//   Modport slave  : the game/stimulus side (drives enable, ticks, buttons).
// Revision    : 1.0 - initial release
// ============================================================================
interface player_action_encoder_if;
    import game_pkg::*;

    logic             enable;
    logic             round_tick;
    logic             btn_right;
    logic             btn_left;
    logic             btn_jump;
    logic             btn_kick;
    logic             btn_punch;
    logic [ACT_W-1:0] action;
    logic             action_strobe;
    logic             busy;

    modport master (
        input  enable, round_tick, btn_right, btn_left, btn_jump, btn_kick, btn_punch,
        output action, action_strobe, busy
    );

    modport slave (
        output enable, round_tick, btn_right, btn_left, btn_jump, btn_kick, btn_punch,
        input  action, action_strobe, busy
    );
endinterface
`default_nettype wire

// File: rtl/btn_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_detect
// Description : Rising-edge detector for synchronised button levels.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   i_btn   : button levels
//   o_press : one-cycle press flags (btn & ~prev)
//   The previous-level register resets to all ones, so a button held
//   through reset never produces a press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_detect #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_btn,
    output logic      [WIDTH-1:0] o_press
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= '1;
        else     r_prev <= i_btn;
    end

    assign o_press = i_btn & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/player_action_encoder.sv
`default_nettype none
// ============================================================================
// Module      : player_action_encoder
// Description : Turns five button levels into one one-hot action per round.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : player_action_encoder_if.master
//          (enable, round_tick, buttons in; action, strobe, busy out)
//   Parameters:
//     MIRROR        : 1 swaps the left/right button mapping
//     JUMP_COOLDOWN : rounds forced to NOP after a JUMP (0..7)
//     CD_W          : cooldown counter width
//   Optional macro ACTION_REPEAT_EN: when defined, an idle round with a
//   held movement button and no new press repeats that movement
//   instead of issuing WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module player_action_encoder
    import game_pkg::*;
#(
    parameter int MIRROR        = 0,
    parameter int JUMP_COOLDOWN = 2,
    parameter int CD_W          = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    player_action_encoder_if.master bus
);

    localparam logic [CD_W-1:0] c_CD_LOAD = CD_W'(JUMP_COOLDOWN);
    localparam logic [CD_W-1:0] c_CD_ONE  = CD_W'(1);
    localparam bit              c_HAS_CD  = (JUMP_COOLDOWN > 0);

    logic [4:0]       w_btn;
    logic [4:0]       w_press;
    logic [4:0]       w_press_map;
    logic [ACT_W-1:0] w_enc;
    logic             w_any_press;
    logic [ACT_W-1:0] w_idle_code;

    state_t           r_state,   w_state_nxt;
    logic [ACT_W-1:0] r_pending, w_pending_nxt;
    logic [CD_W-1:0]  r_count,   w_count_nxt;
    logic [ACT_W-1:0] r_action,  w_action_nxt;
    logic             r_strobe,  w_strobe_nxt;

    // Bit order {right, left, jump, kick, punch}.
    assign w_btn = {bus.btn_right, bus.btn_left, bus.btn_jump, bus.btn_kick, bus.btn_punch};

    btn_edge_detect #(.WIDTH(5)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (w_btn),
        .o_press (w_press)
    );

    // Mirroring happens before priority so priority works on the encoded code.
    generate
        if (MIRROR != 0) begin : g_mirror
            assign w_press_map = {w_press[3], w_press[4], w_press[2:0]};
        end else begin : g_direct
            assign w_press_map = w_press;
        end
    endgenerate

    assign w_enc       = encode_press(w_press_map);
    assign w_any_press = |w_press_map;

`ifdef ACTION_REPEAT_EN
    // Held levels after mirroring: [1] = move-left code, [0] = move-right code.
    logic [1:0] w_move_lvl;
    generate
        if (MIRROR != 0) begin : g_lvl_mirror
            assign w_move_lvl = {bus.btn_right, bus.btn_left};
        end else begin : g_lvl_direct
            assign w_move_lvl = {bus.btn_left, bus.btn_right};
        end
    endgenerate
    always_comb begin
        w_idle_code = ACT_WAIT;
        if (!w_any_press) begin
            if (w_move_lvl[1])      w_idle_code = ACT_MOVE_LEFT;
            else if (w_move_lvl[0]) w_idle_code = ACT_MOVE_RIGHT;
        end
    end
`else
    assign w_idle_code = ACT_WAIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= ACT_NOP;
            r_count   <= '0;
            r_action  <= ACT_NOP;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_action  <= w_action_nxt;
            r_strobe  <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        w_action_nxt  = r_action;
        w_strobe_nxt  = 1'b0;

        if (!bus.enable) begin
            w_state_nxt   = IDLE;
            w_pending_nxt = ACT_NOP;
            w_count_nxt   = '0;
            w_action_nxt  = ACT_NOP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.round_tick) begin
                        w_action_nxt = w_idle_code;
                        w_strobe_nxt = 1'b1;
                    end
                    // A press coincident with a tick belongs to the next round.
                    if (w_any_press) begin
                        w_pending_nxt = w_enc;
                        w_state_nxt   = ARMED;
                    end
                end
                ARMED: begin
                    if (bus.round_tick) begin
                        w_action_nxt  = r_pending;
                        w_strobe_nxt  = 1'b1;
                        w_pending_nxt = ACT_NOP;
                        if (c_HAS_CD && (r_pending == ACT_JUMP)) begin
                            // Entering cooldown drops any coincident press.
                            w_state_nxt = COOLDOWN;
                            w_count_nxt = c_CD_LOAD;
                        end else if (w_any_press) begin
                            w_pending_nxt = w_enc;
                            w_state_nxt   = ARMED;
                        end else begin
                            w_state_nxt   = IDLE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (bus.round_tick) begin
                        w_action_nxt = ACT_NOP;
                        w_strobe_nxt = 1'b1;
                        w_count_nxt  = r_count - c_CD_ONE;
                        if (r_count <= c_CD_ONE) begin
                            w_count_nxt = '0;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_pending_nxt = ACT_NOP;
                    w_count_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.action        = r_action;
    assign bus.action_strobe = r_strobe;
    assign bus.busy          = (r_state == COOLDOWN);

endmodule
`default_nettype wire
